keypad_number_entry: RTL and testbench
======================================

# keypad_number_entry

Multi-digit decimal entry block between the PS/2 keyboard decoder and the game controller. It accepts make/break events, tracks a single held key, and accumulates up to DIGITS decimal digits. Digits come from both the top-row and numeric-pad keys. It supports backspace, clear and range-checked commit, and presents each committed number to the consumer through a valid/ready handshake.

## Interface
- DIGITS, 2, maximum digits in the edit buffer (1..4)
- MIN_VALUE, 1, smallest value that may be committed
- MAX_VALUE, 25, largest value that may be committed
- VALUE_W, $clog2(10**DIGITS), width of out_value (derived; not overridden)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  single-cycle strobe: key event present on last_change
- last_change  in  9  scan code of the event ({E0 flag, 8-bit code})
- key_pressed  in  1  key_down[last_change]; 1 = make, 0 = break
- digits_bcd  out  4*DIGITS  edit buffer; least-significant digit in [3:0]
- digit_count  out  $clog2(DIGITS+1)  number of digits currently entered
- out_value  out  VALUE_W  committed binary value
- out_valid  out  1  committed value pending
- out_ready  in  1  consumer accepts out_value
- err_pulse  out  1  one-cycle pulse for a rejected action
- key_held  out  1  a recognised key is currently locked

## Operation
- Key classes, decoded from last_change:
  - DIGIT: top row 45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9; keypad 70,69,72,7A,6B,73,74,6C,75,7D map to 0..9.
  - ENTER: 05A or 15A.
  - BKSP: 066.
  - CLEAR: 076 (Esc).
  - NONE: any other code.
- Accepted event: key_valid & key_pressed & !key_held & class != NONE.
  - Sets key_held and stores held_code = last_change.
- Release: key_valid & !key_pressed & key_held & last_change == held_code.
  - Clears key_held.
  - Breaks of any other code are ignored.
  - Makes while key_held are ignored; this covers typematic repeats.
- FSM states EDIT and COMMIT. Reset enters EDIT.
- EDIT, on an accepted event:
  - DIGIT with count < DIGITS: shift the buffer left one digit, insert the new digit at [3:0], count++.
  - DIGIT with count == DIGITS: buffer unchanged, err_pulse.
  - BKSP with count > 0: shift the buffer right one digit, zero-fill the top digit, count--.
  - BKSP with count == 0: err_pulse.
  - CLEAR: buffer zeroed, count = 0, no error.
  - ENTER: v = binary(digits_bcd).
    - If count > 0 and MIN_VALUE ≤ v ≤ MAX_VALUE: out_value = v, out_valid = 1, buffer cleared, go to COMMIT.
    - Otherwise: err_pulse and buffer cleared.
- COMMIT:
  - All accepted events still update the key lock, but do not touch the buffer and raise no error.
  - out_valid & out_ready: out_valid = 0, return to EDIT.
- out_value holds its last committed value after the handshake.
- Leading zeros count as digits: "0","7" gives count 2, value 7.

## Timing
- All outputs are registered. Every effect of an event at edge N is visible after edge N.
- err_pulse is high for exactly the one cycle following the offending event.
- out_valid rises the cycle after an accepted ENTER. It stays high until the cycle after the first cycle with out_ready = 1.
- An event in the same cycle as the COMMIT handshake is evaluated in COMMIT, so it is ignored. The key lock still updates.
- out_ready while out_valid = 0 has no effect.
- Reset values: digits_bcd = 0, digit_count = 0, out_value = 0, out_valid = 0, err_pulse = 0, key_held = 0, held_code = 0, state = EDIT.
- Reset mid-entry or mid-handshake discards everything immediately (asynchronous).
- BCD-to-binary conversion is combinational. It must close timing for DIGITS = 4 at the system clock.

## Structure
- Package keypad_pkg holds:
  - the scan-code constants (20 digit codes, ENTER ×2, BKSP, CLEAR);
  - the key-class enum {KEY_NONE, KEY_DIGIT, KEY_ENTER, KEY_BKSP, KEY_CLEAR};
  - the FSM state enum.
- Sub-module keycode_classifier (combinational): last_change in; key class and 4-bit digit out. It is reusable by other keyboard consumers.
- The top level holds the lock, FSM, buffer, and range check.

## Test plan
- Press and release "1", then "8", then ENTER (5A) → digits_bcd 0x18 before ENTER; after ENTER out_valid = 1, out_value = 18, digit_count = 0. Hold out_ready low for 5 cycles: out_valid stays 1; raise it → out_valid = 0 the next cycle.
- Keypad "2" (72), keypad "6" (74), ENTER (15A) → value 26 > MAX_VALUE: err_pulse for 1 cycle, out_valid stays 0, buffer cleared.
- Digits "3","4", third digit "5" → err_pulse, buffer stays 0x34. Then BKSP → 0x03, count 1. Then ESC → 0x00, count 0. Then BKSP → err_pulse.
- Make "1", then make "2" while "1" is held, break "2", break "1", make "2" → only 1 then 2 enter the buffer (0x12). key_held goes 1,1,1,0,1 across the events.
- ENTER on an empty buffer → err_pulse. "0" then ENTER → err_pulse (0 < MIN_VALUE).
- Commit "5", then press "9" while out_valid = 1 (ready low) → buffer unchanged, no err_pulse. Assert rst mid-sequence → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/keypad_number_entry_pkg.sv
// Shared scan-code constants, key classes and FSM states for keyboard-driven
// number entry.
package keypad_pkg;

    localparam logic [8:0] SC_0 = 9'h045;
    localparam logic [8:0] SC_1 = 9'h016;
    localparam logic [8:0] SC_2 = 9'h01E;
    localparam logic [8:0] SC_3 = 9'h026;
    localparam logic [8:0] SC_4 = 9'h025;
    localparam logic [8:0] SC_5 = 9'h02E;
    localparam logic [8:0] SC_6 = 9'h036;
    localparam logic [8:0] SC_7 = 9'h03D;
    localparam logic [8:0] SC_8 = 9'h03E;
    localparam logic [8:0] SC_9 = 9'h046;

    localparam logic [8:0] SC_KP0 = 9'h070;
    localparam logic [8:0] SC_KP1 = 9'h069;
    localparam logic [8:0] SC_KP2 = 9'h072;
    localparam logic [8:0] SC_KP3 = 9'h07A;
    localparam logic [8:0] SC_KP4 = 9'h06B;
    localparam logic [8:0] SC_KP5 = 9'h073;
    localparam logic [8:0] SC_KP6 = 9'h074;
    localparam logic [8:0] SC_KP7 = 9'h06C;
    localparam logic [8:0] SC_KP8 = 9'h075;
    localparam logic [8:0] SC_KP9 = 9'h07D;

    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_BKSP     = 9'h066;
    localparam logic [8:0] SC_CLEAR    = 9'h076;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_ENTER,
        KEY_BKSP,
        KEY_CLEAR
    } key_class_t;

    typedef enum logic {
        ST_EDIT,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/keypad_number_entry_if.sv
// Key-event input and committed-value handshake bundle for keypad_number_entry.
interface keypad_number_entry_if #(
    parameter int DIGITS = 2
);
    localparam int VALUE_W = $clog2(10**DIGITS);
    localparam int CNT_W   = $clog2(DIGITS + 1);

    logic                  key_valid;
    logic [8:0]            last_change;
    logic                  key_pressed;
    logic [4*DIGITS-1:0]   digits_bcd;
    logic [CNT_W-1:0]      digit_count;
    logic [VALUE_W-1:0]    out_value;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_pulse;
    logic                  key_held;

    modport master (
        output key_valid, last_change, key_pressed, out_ready,
        input  digits_bcd, digit_count, out_value, out_valid, err_pulse, key_held
    );

    modport slave (
        input  key_valid, last_change, key_pressed, out_ready,
        output digits_bcd, digit_count, out_value, out_valid, err_pulse, key_held
    );
endinterface

// File: rtl/keypad_number_entry_classifier.sv
// Combinational PS/2 scan-code classifier: key class plus decimal value for
// top-row and numeric-pad digits.
module keycode_classifier
    import keypad_pkg::*;
(
    input  logic [8:0]  i_last_change,
    output key_class_t  o_class,
    output logic [3:0]  o_digit
);

    always_comb begin
        o_class = KEY_NONE;
        o_digit = 4'd0;
        case (i_last_change)
            SC_0, SC_KP0: begin o_class = KEY_DIGIT; o_digit = 4'd0; end
            SC_1, SC_KP1: begin o_class = KEY_DIGIT; o_digit = 4'd1; end
            SC_2, SC_KP2: begin o_class = KEY_DIGIT; o_digit = 4'd2; end
            SC_3, SC_KP3: begin o_class = KEY_DIGIT; o_digit = 4'd3; end
            SC_4, SC_KP4: begin o_class = KEY_DIGIT; o_digit = 4'd4; end
            SC_5, SC_KP5: begin o_class = KEY_DIGIT; o_digit = 4'd5; end
            SC_6, SC_KP6: begin o_class = KEY_DIGIT; o_digit = 4'd6; end
            SC_7, SC_KP7: begin o_class = KEY_DIGIT; o_digit = 4'd7; end
            SC_8, SC_KP8: begin o_class = KEY_DIGIT; o_digit = 4'd8; end
            SC_9, SC_KP9: begin o_class = KEY_DIGIT; o_digit = 4'd9; end
            SC_ENTER, SC_KP_ENTER: o_class = KEY_ENTER;
            SC_BKSP:  o_class = KEY_BKSP;
            SC_CLEAR: o_class = KEY_CLEAR;
            default:  o_class = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/keypad_number_entry.sv
// Multi-digit decimal entry: single-key lock, BCD edit buffer with
// backspace/clear, range-checked commit and valid/ready output.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int          DIGITS    = 2,
    parameter int unsigned MIN_VALUE = 1,
    parameter int unsigned MAX_VALUE = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_number_entry_if.slave  bus
);

    localparam int VALUE_W = $clog2(10**DIGITS);
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int BUF_W   = 4 * DIGITS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DIGITS);

    // Weighted sum rather than a Horner chain keeps the path shallow at 4 digits.
    function automatic logic [VALUE_W-1:0] bcd_to_bin(input logic [BUF_W-1:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < DIGITS; i++)
            acc = acc + 32'(b[4*i +: 4]) * 32'(10**i);
        return VALUE_W'(acc);
    endfunction

    key_class_t          w_class;
    logic [3:0]          w_digit;
    logic                w_accept;
    logic                w_release;
    logic                w_in_range;
    logic [BUF_W-1:0]    w_shl;
    logic [BUF_W-1:0]    w_shr;
    logic [VALUE_W-1:0]  w_value;

    state_t              r_state;
    logic [BUF_W-1:0]    r_buf;
    logic [CNT_W-1:0]    r_count;
    logic [VALUE_W-1:0]  r_out_value;
    logic                r_out_valid;
    logic                r_err;
    logic                r_key_held;
    logic [8:0]          r_held_code;

    keycode_classifier u_classifier (
        .i_last_change (bus.last_change),
        .o_class       (w_class),
        .o_digit       (w_digit)
    );

    assign w_accept  = bus.key_valid & bus.key_pressed & ~r_key_held & (w_class != KEY_NONE);
    assign w_release = bus.key_valid & ~bus.key_pressed & r_key_held &
                       (bus.last_change == r_held_code);

    always_comb begin
        w_shl      = r_buf << 4;
        w_shl[3:0] = w_digit;
        w_shr      = r_buf >> 4;
        w_value    = bcd_to_bin(r_buf);
        w_in_range = (r_count != '0) &&
                     (32'(w_value) >= MIN_VALUE) && (32'(w_value) <= MAX_VALUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EDIT;
            r_buf       <= '0;
            r_count     <= '0;
            r_out_value <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_key_held  <= 1'b0;
            r_held_code <= '0;
        end else begin
            r_err <= 1'b0;

            // The lock tracks events in both states; only EDIT acts on them.
            if (w_accept) begin
                r_key_held  <= 1'b1;
                r_held_code <= bus.last_change;
            end else if (w_release) begin
                r_key_held  <= 1'b0;
            end

            case (r_state)
                ST_EDIT: begin
                    if (w_accept) begin
                        case (w_class)
                            KEY_DIGIT: begin
                                if (r_count < FULL_CNT) begin
                                    r_buf   <= w_shl;
                                    r_count <= r_count + CNT_W'(1);
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            KEY_BKSP: begin
                                if (r_count != '0) begin
                                    r_buf   <= w_shr;
                                    r_count <= r_count - CNT_W'(1);
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            KEY_CLEAR: begin
                                r_buf   <= '0;
                                r_count <= '0;
                            end
                            KEY_ENTER: begin
                                r_buf   <= '0;
                                r_count <= '0;
                                if (w_in_range) begin
                                    r_out_value <= w_value;
                                    r_out_valid <= 1'b1;
                                    r_state     <= ST_COMMIT;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_COMMIT: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EDIT;
                    end
                end
                default: r_state <= ST_EDIT;
            endcase
        end
    end

    assign bus.digits_bcd  = r_buf;
    assign bus.digit_count = r_count;
    assign bus.out_value   = r_out_value;
    assign bus.out_valid   = r_out_valid;
    assign bus.err_pulse   = r_err;
    assign bus.key_held    = r_key_held;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry: entry, editing, key lock, range
// checks, commit handshake and asynchronous reset.
module tb_keypad_number_entry;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    keypad_number_entry_if #(.DIGITS(2)) bus ();

    keypad_number_entry #(.DIGITS(2), .MIN_VALUE(1), .MAX_VALUE(25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One event strobe, returning at the falling edge after it was sampled.
    task automatic ev(input logic [8:0] code, input logic pressed);
        @(negedge clk);
        bus.key_valid   = 1'b1;
        bus.last_change = code;
        bus.key_pressed = pressed;
        @(negedge clk);
        bus.key_valid   = 1'b0;
        bus.key_pressed = 1'b0;
    endtask

    task automatic make(input logic [8:0] code);  ev(code, 1'b1); endtask
    task automatic brk(input logic [8:0] code);   ev(code, 1'b0); endtask
    task automatic tap(input logic [8:0] code);   make(code); brk(code); endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bus.digits_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_digits: got %h want 00", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.digit_count); end
        n_checks++; if (bus.out_value !== 7'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", bus.out_value); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_pulse); end
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", bus.key_held); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_commit_handshake();
        tap(9'h016); tap(9'h03E);
        n_checks++; if (bus.digits_bcd !== 8'h18) begin n_fail++; $display("FAIL hs_digits: got %h want 18", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd2) begin n_fail++; $display("FAIL hs_count: got %0d want 2", bus.digit_count); end
        make(9'h05A);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hs_valid: got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_value !== 7'd18) begin n_fail++; $display("FAIL hs_value: got %0d want 18", bus.out_value); end
        n_checks++; if (bus.digit_count !== 2'd0) begin n_fail++; $display("FAIL hs_cleared: got %0d want 0", bus.digit_count); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL hs_noerr: got %b want 0", bus.err_pulse); end
        brk(9'h05A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hs_hold%0d: got %b want 1", i, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hs_accept: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_value !== 7'd18) begin n_fail++; $display("FAIL hs_keep: got %0d want 18", bus.out_value); end
    endtask

    task automatic test_range_reject();
        tap(9'h072); tap(9'h074);
        n_checks++; if (bus.digits_bcd !== 8'h26) begin n_fail++; $display("FAIL kp_digits: got %h want 26", bus.digits_bcd); end
        make(9'h15A);
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL rng_err: got %b want 1", bus.err_pulse); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rng_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.digits_bcd !== 8'h00) begin n_fail++; $display("FAIL rng_digits: got %h want 00", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd0) begin n_fail++; $display("FAIL rng_count: got %0d want 0", bus.digit_count); end
        brk(9'h15A);
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL rng_errlen: got %b want 0", bus.err_pulse); end
    endtask

    task automatic test_edit();
        tap(9'h026); tap(9'h025);
        make(9'h02E);
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b want 1", bus.err_pulse); end
        n_checks++; if (bus.digits_bcd !== 8'h34) begin n_fail++; $display("FAIL full_digits: got %h want 34", bus.digits_bcd); end
        brk(9'h02E);
        make(9'h066);
        n_checks++; if (bus.digits_bcd !== 8'h03) begin n_fail++; $display("FAIL bksp_digits: got %h want 03", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd1) begin n_fail++; $display("FAIL bksp_count: got %0d want 1", bus.digit_count); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL bksp_noerr: got %b want 0", bus.err_pulse); end
        brk(9'h066);
        make(9'h076);
        n_checks++; if (bus.digits_bcd !== 8'h00) begin n_fail++; $display("FAIL clr_digits: got %h want 00", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", bus.digit_count); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL clr_noerr: got %b want 0", bus.err_pulse); end
        brk(9'h076);
        make(9'h066);
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL bksp_empty: got %b want 1", bus.err_pulse); end
        brk(9'h066);
    endtask

    task automatic test_key_lock();
        make(9'h016);
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL lock_a: got %b want 1", bus.key_held); end
        make(9'h01E);
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL lock_b: got %b want 1", bus.key_held); end
        n_checks++; if (bus.digits_bcd !== 8'h01) begin n_fail++; $display("FAIL lock_ignore: got %h want 01", bus.digits_bcd); end
        brk(9'h01E);
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL lock_c: got %b want 1", bus.key_held); end
        brk(9'h016);
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL lock_d: got %b want 0", bus.key_held); end
        make(9'h01E);
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL lock_e: got %b want 1", bus.key_held); end
        n_checks++; if (bus.digits_bcd !== 8'h12) begin n_fail++; $display("FAIL lock_digits: got %h want 12", bus.digits_bcd); end
        brk(9'h01E);
        tap(9'h076);
    endtask

    task automatic test_enter_errors();
        make(9'h05A);
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL empty_enter: got %b want 1", bus.err_pulse); end
        brk(9'h05A);
        tap(9'h045);
        n_checks++; if (bus.digit_count !== 2'd1) begin n_fail++; $display("FAIL zero_count: got %0d want 1", bus.digit_count); end
        make(9'h05A);
        n_checks++; if (bus.err_pulse !== 1'b1) begin n_fail++; $display("FAIL zero_enter: got %b want 1", bus.err_pulse); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b want 0", bus.out_valid); end
        brk(9'h05A);
        tap(9'h045); tap(9'h03D);
        n_checks++; if (bus.digit_count !== 2'd2) begin n_fail++; $display("FAIL lead_count: got %0d want 2", bus.digit_count); end
        tap(9'h05A);
        n_checks++; if (bus.out_value !== 7'd7) begin n_fail++; $display("FAIL lead_value: got %0d want 7", bus.out_value); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_commit_ignore();
        tap(9'h02E); tap(9'h05A);
        n_checks++; if (bus.out_value !== 7'd5) begin n_fail++; $display("FAIL c5_value: got %0d want 5", bus.out_value); end
        make(9'h046);
        n_checks++; if (bus.digits_bcd !== 8'h00) begin n_fail++; $display("FAIL c5_digits: got %h want 00", bus.digits_bcd); end
        n_checks++; if (bus.err_pulse !== 1'b0) begin n_fail++; $display("FAIL c5_noerr: got %b want 0", bus.err_pulse); end
        n_checks++; if (bus.key_held !== 1'b1) begin n_fail++; $display("FAIL c5_held: got %b want 1", bus.key_held); end
        make(9'h03D);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL c5_accept: got %b want 0", bus.out_valid); end
        brk(9'h046);
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL c5_release: got %b want 0", bus.key_held); end
    endtask

    task automatic test_async_reset();
        tap(9'h03D); tap(9'h05A);
        make(9'h026);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got %b want 1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_value !== 7'd0) begin n_fail++; $display("FAIL ar_value: got %0d want 0", bus.out_value); end
        n_checks++; if (bus.key_held !== 1'b0) begin n_fail++; $display("FAIL ar_held: got %b want 0", bus.key_held); end
        n_checks++; if (bus.digit_count !== 2'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", bus.digit_count); end
        @(negedge clk);
        rst = 1'b0;
        make(9'h025);
        n_checks++; if (bus.digits_bcd !== 8'h04) begin n_fail++; $display("FAIL ar_after: got %h want 04", bus.digits_bcd); end
        n_checks++; if (bus.digit_count !== 2'd1) begin n_fail++; $display("FAIL ar_after_cnt: got %0d want 1", bus.digit_count); end
        brk(9'h025);
    endtask

    initial begin
        bus.key_valid   = 1'b0;
        bus.last_change = 9'h000;
        bus.key_pressed = 1'b0;
        bus.out_ready   = 1'b0;
        test_reset();
        test_commit_handshake();
        test_range_reject();
        test_edit();
        test_key_lock();
        test_enter_errors();
        test_commit_ignore();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
